// File: rtl/if_fetch_core.sv
// Instruction-fetch sequencer: owns the fetch PC, issues single-outstanding
// icache reads and presents each returned word to the RF stage as a pulse.
module if_fetch_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic        icache_rvalid,
  input  logic [31:0] icache_rdata,
  output logic        rf_valid,
  output logic        rf_load,
  output logic [31:0] rf_instr,
  output logic [31:0] rf_pc,
  input  logic        rf_pc_update,
  input  logic        rf_stall,
  input  logic        rf_recover,
  input  logic        rf_clear,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]  state;
  logic        pend;
  logic        redir;
  logic [31:0] pend_addr;
  logic        accept;
  logic [31:0] next_pc;

  assign accept  = icache_req && icache_ready;
  assign next_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC) : rf_pc + 32'd4;
  assign rf_load = rf_valid && (rf_instr[31:29] == 3'b100);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      icache_req  <= 1'b0;
      icache_addr <= RESET_VECTOR;
      rf_valid    <= 1'b0;
      rf_instr    <= 32'h0;
      rf_pc       <= RESET_VECTOR;
      pend        <= 1'b0;
      redir       <= 1'b0;
      pend_addr   <= EXC_VECTOR;
    end else begin
      // NOTE: rf_valid defaults low every cycle, so each set below is a one-cycle pulse.
      rf_valid <= 1'b0;
      case (state)
        BOOT: begin
          state      <= REQ;
          icache_req <= 1'b1;
          pend       <= 1'b0;
          if (rf_clear) icache_addr <= EXC_VECTOR;
        end

        REQ: begin
          // The presented address must stay stable until accepted, so a clear
          // here only remembers the redirect.
          if (rf_clear && !redir) begin
            redir     <= 1'b1;
            pend_addr <= EXC_VECTOR;
          end
          if (accept) begin
            icache_req <= 1'b0;
            state      <= (redir || rf_clear) ? DRAIN : WAIT;
          end
        end

        WAIT: begin
          if (rf_clear) begin
            pend_addr <= EXC_VECTOR;
            if (icache_rvalid) begin
              // The response being cancelled is arriving now; nothing left to drain.
              icache_addr <= EXC_VECTOR;
              icache_req  <= 1'b1;
              state       <= REQ;
            end else begin
              state <= DRAIN;
            end
          end else if (icache_rvalid) begin
            rf_instr <= icache_rdata;
            rf_pc    <= icache_addr;
            state    <= HOLD;
            if (rf_stall) pend <= 1'b1;
            else          rf_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (rf_clear) begin
            icache_addr <= EXC_VECTOR;
            icache_req  <= 1'b1;
            pend        <= 1'b0;
            state       <= REQ;
          end else if (rf_pc_update) begin
            icache_addr <= next_pc;
            icache_req  <= 1'b1;
            pend        <= 1'b0;
            state       <= REQ;
          end else begin
            // A recover and an owed pulse collapse into a single presentation.
            rf_valid <= !rf_stall && (pend || rf_recover);
            pend     <= rf_stall && (pend || rf_recover);
          end
        end

        DRAIN: begin
          if (icache_rvalid) begin
            icache_addr <= pend_addr;
            icache_req  <= 1'b1;
            redir       <= 1'b0;
            state       <= REQ;
          end
        end

        default: begin
          state      <= BOOT;
          icache_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_core.sv
// Self-checking bench for if_fetch_core: directed scenarios plus a randomized
// phase, all checked against a transaction-level fetch/presentation model.
module tb_if_fetch_core;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic        icache_rvalid;
  logic [31:0] icache_rdata;
  logic        rf_valid;
  logic        rf_load;
  logic [31:0] rf_instr;
  logic [31:0] rf_pc;
  logic        rf_pc_update;
  logic        rf_stall;
  logic        rf_recover;
  logic        rf_clear;
  logic        branch_taken;
  logic [31:0] branch_target;

  always #5 clk = ~clk;

  if_fetch_core dut (
    .clk           (clk),
    .rst           (rst),
    .icache_req    (icache_req),
    .icache_addr   (icache_addr),
    .icache_ready  (icache_ready),
    .icache_rvalid (icache_rvalid),
    .icache_rdata  (icache_rdata),
    .rf_valid      (rf_valid),
    .rf_load       (rf_load),
    .rf_instr      (rf_instr),
    .rf_pc         (rf_pc),
    .rf_pc_update  (rf_pc_update),
    .rf_stall      (rf_stall),
    .rf_recover    (rf_recover),
    .rf_clear      (rf_clear),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Cache responder state
  bit          busy;
  int          cnt;
  logic [31:0] resp_addr;
  int          lat_lo, lat_hi;
  bit          rand_ready;
  int          ready_block;

  // Reference model: the outstanding fetch, the held instruction and owed presentations
  bit          in_reset;
  bit          boot;
  bit          held;
  bit          cur_drop;
  bit          owe;
  logic [31:0] cur_addr;
  logic [31:0] hold_pc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == RESET_VECTOR)              return 32'h2408_0001;
    if (a == RESET_VECTOR + 32'd4)      return 32'h8C82_0000;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive the cache, advance the model, clock the DUT, compare.
  task automatic tick();
    logic        acc, rv, pulse, req_before;
    logic [31:0] addr_before, exp_instr;
    icache_rvalid = busy && (cnt == 0);
    icache_rdata  = busy ? data_of(resp_addr) : 32'hDEAD_BEEF;
    icache_ready  = (ready_block > 0) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    acc         = icache_req && icache_ready;
    rv          = icache_rvalid;
    req_before  = icache_req;
    addr_before = icache_addr;
    pulse       = 1'b0;
    if (!in_reset) begin
      if (acc) begin
        check("accept_addr", icache_addr, cur_addr);
        check_bit("single_outstanding", busy, 1'b0);
      end
      if (boot) begin
        boot = 1'b0;
        if (rf_clear) cur_addr = EXC_VECTOR;
      end else if (rf_clear) begin
        if (held) begin
          held = 1'b0; owe = 1'b0; cur_drop = 1'b0; cur_addr = EXC_VECTOR;
        end else begin
          cur_drop = 1'b1;
        end
      end else if (rf_pc_update && held) begin
        held = 1'b0; owe = 1'b0;
        cur_addr = branch_taken ? (branch_target & 32'hFFFF_FFFC) : hold_pc + 32'd4;
      end else if (rf_recover && held) begin
        owe = 1'b1;
      end
      if (rv) begin
        if (cur_drop) begin
          cur_drop = 1'b0; cur_addr = EXC_VECTOR;
        end else begin
          held = 1'b1; hold_pc = cur_addr; owe = 1'b1;
        end
      end
      if (held && owe && !rf_stall) begin
        pulse = 1'b1; owe = 1'b0;
      end
    end

    @(posedge clk); #1;

    if (rv) busy = 1'b0;
    else if (busy && cnt > 0) cnt--;
    if (acc) begin
      busy      = 1'b1;
      cnt       = int'($urandom_range(lat_hi, lat_lo)) - 1;
      resp_addr = addr_before;
    end
    if (ready_block > 0 && req_before) ready_block--;

    if (!in_reset) begin
      exp_instr = data_of(hold_pc);
      check_bit("rf_valid", rf_valid, pulse);
      check_bit("rf_load", rf_load, pulse && (exp_instr[31:29] == 3'b100));
      if (pulse) begin
        check("rf_pc", rf_pc, hold_pc);
        check("rf_instr", rf_instr, exp_instr);
      end
      if (req_before && !acc) begin
        check_bit("req_held", icache_req, 1'b1);
        check("addr_stable", icache_addr, addr_before);
      end
      if (held) check_bit("no_req_while_held", icache_req, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_reset = 1'b1; busy = 1'b0; ready_block = 0;
    rf_pc_update = 1'b0; rf_stall = 1'b0; rf_recover = 1'b0; rf_clear = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    icache_ready = 1'b0; icache_rvalid = 1'b0; icache_rdata = 32'h0;
    #1;
    check_bit("rst_req", icache_req, 1'b0);
    check("rst_addr", icache_addr, RESET_VECTOR);
    check_bit("rst_valid", rf_valid, 1'b0);
    check_bit("rst_load", rf_load, 1'b0);
    check("rst_instr", rf_instr, 32'h0);
    check("rst_pc", rf_pc, RESET_VECTOR);
    tick(); tick();
    check_bit("rst_req_held_low", icache_req, 1'b0);
    held = 1'b0; cur_drop = 1'b0; owe = 1'b0; cur_addr = RESET_VECTOR; boot = 1'b1;
    rst = 1'b0; in_reset = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int max);
    for (int i = 0; i < max && !rf_valid; i++) tick();
    check_bit(tag, rf_valid, 1'b1);
  endtask

  task automatic wait_req(input string tag, input int max);
    for (int i = 0; i < max && !icache_req; i++) tick();
    check_bit(tag, icache_req, 1'b1);
  endtask

  task automatic update(input logic taken, input logic [31:0] tgt);
    rf_pc_update = 1'b1; branch_taken = taken; branch_target = tgt;
    tick();
    rf_pc_update = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    lat_lo = 1; lat_hi = 1; rand_ready = 1'b0;
    do_reset();

    // First fetch after reset, sequential next address
    tick();
    check_bit("boot_req", icache_req, 1'b1);
    check("boot_addr", icache_addr, RESET_VECTOR);
    wait_pulse("first_pulse", 10);
    check("first_pc", rf_pc, RESET_VECTOR);
    check_bit("first_load", rf_load, 1'b0);
    check("first_instr", rf_instr, 32'h2408_0001);
    tick();
    check_bit("pulse_one_cycle", rf_valid, 1'b0);
    update(1'b0, 32'h0);
    check_bit("seq_req", icache_req, 1'b1);
    check("seq_addr", icache_addr, RESET_VECTOR + 32'd4);

    // Best-case loop: presentation on the third cycle counting the update
    tick(); tick();
    check_bit("loop_latency", rf_valid, 1'b1);
    check_bit("lw_load", rf_load, 1'b1);
    check("lw_pc", rf_pc, RESET_VECTOR + 32'd4);
    tick();
    check_bit("lw_load_drop", rf_load, 1'b0);
    update(1'b1, 32'h8001_0003);
    check("branch_addr", icache_addr, 32'h8001_0000);
    wait_pulse("branch_pulse", 10);

    // Stall across the response, then recover with and without stall
    update(1'b0, 32'h0);
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("stalled_no_pulse", rf_valid, 1'b0);
    end
    rf_stall = 1'b0;
    tick();
    check_bit("stall_release_pulse", rf_valid, 1'b1);
    check("stall_release_pc", rf_pc, 32'h8001_0004);
    tick();
    check_bit("stall_single_pulse", rf_valid, 1'b0);
    rf_recover = 1'b1; tick(); rf_recover = 1'b0;
    check_bit("recover_pulse", rf_valid, 1'b1);
    check("recover_pc", rf_pc, 32'h8001_0004);
    tick();
    check_bit("recover_single", rf_valid, 1'b0);
    rf_stall = 1'b1; rf_recover = 1'b1; tick(); rf_recover = 1'b0;
    check_bit("recover_stalled", rf_valid, 1'b0);
    tick();
    rf_stall = 1'b0; tick();
    check_bit("recover_deferred_pulse", rf_valid, 1'b1);
    tick();

    // Clear while awaiting a slow response
    lat_lo = 5; lat_hi = 5;
    update(1'b0, 32'h0);
    tick();
    check_bit("in_wait_no_req", icache_req, 1'b0);
    rf_clear = 1'b1; tick(); rf_clear = 1'b0;
    wait_req("drain_req", 12);
    check("wait_clear_exc_addr", icache_addr, EXC_VECTOR);
    lat_lo = 1; lat_hi = 1;
    wait_pulse("exc_pulse", 10);
    check("exc_pc", rf_pc, EXC_VECTOR);

    // Clear while a request is being held off by the cache
    ready_block = 3;
    update(1'b0, 32'h0);
    check_bit("req_before_clear", icache_req, 1'b1);
    rf_clear = 1'b1; tick(); rf_clear = 1'b0;
    check("redir_addr_stable", icache_addr, EXC_VECTOR + 32'd4);
    rf_clear = 1'b1; tick(); rf_clear = 1'b0;
    for (int i = 0; i < 10 && icache_req; i++) tick();
    check_bit("redir_accepted", icache_req, 1'b0);
    wait_req("redir_req", 10);
    check("redir_exc_addr", icache_addr, EXC_VECTOR);
    wait_pulse("redir_pulse", 10);

    // Sequential address wraps at the top of the address space
    update(1'b1, 32'hFFFF_FFFE);
    wait_pulse("top_pulse", 10);
    check("top_pc", rf_pc, 32'hFFFF_FFFC);
    update(1'b0, 32'h0);
    check("wrap_addr", icache_addr, 32'h0000_0000);
    wait_pulse("wrap_pulse", 10);

    // Clear on the very first cycle after reset
    do_reset();
    rf_clear = 1'b1; tick(); rf_clear = 1'b0;
    check_bit("boot_clear_req", icache_req, 1'b1);
    check("boot_clear_addr", icache_addr, EXC_VECTOR);
    wait_pulse("boot_clear_pulse", 10);

    // Randomized traffic against the model
    rand_ready = 1'b1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      rf_stall      = ($urandom_range(0, 3) == 0);
      rf_recover    = ($urandom_range(0, 7) == 0);
      rf_pc_update  = ($urandom_range(0, 3) == 0);
      rf_clear      = ($urandom_range(0, 24) == 0);
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      tick();
    end

    // Reset in the middle of a fetch
    rf_pc_update = 1'b0; rf_recover = 1'b0; rf_clear = 1'b0; rf_stall = 1'b0;
    for (int i = 0; i < 50 && !(icache_req || busy); i++) tick();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rf_stall      = ($urandom_range(0, 3) == 0);
      rf_recover    = ($urandom_range(0, 7) == 0);
      rf_pc_update  = ($urandom_range(0, 2) == 0);
      rf_clear      = ($urandom_range(0, 30) == 0);
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_core.md
# if_fetch_core

Instruction-fetch sequencer that feeds the RF stage. It owns the fetch PC and issues single-outstanding reads to the instruction cache. It presents each returned word to the RF-stage controller as a one-cycle `rf_valid` pulse, then holds it until that controller advances (`rf_pc_update`), replays it (`rf_recover`) or cancels it (`rf_clear`). It is the producer end of the RF handshake.

## Interface
- `RESET_VECTOR`, 32'hBFC0_0000: first fetch address after reset.
- `EXC_VECTOR`, 32'h8000_0080: fetch address after `rf_clear`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `icache_req`  out  1  read request; held until accepted.
- `icache_addr`  out  32  word address; bits [1:0] always 0.
- `icache_ready`  in  1  request accepted when `icache_req && icache_ready`.
- `icache_rvalid`  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- `icache_rdata`  in  32  instruction word.
- `rf_valid`  out  1  one-cycle pulse: `rf_instr`/`rf_pc` are newly presented.
- `rf_load`  out  1  `rf_valid && rf_instr[31:29]==3'b100`.
- `rf_instr`  out  32  held instruction.
- `rf_pc`  out  32  address of held instruction.
- `rf_pc_update`  in  1  consume held instruction and fetch the next one.
- `rf_stall`  in  1  backend stalled; defer `rf_valid` pulses.
- `rf_recover`  in  1  re-pulse `rf_valid` for the held instruction.
- `rf_clear`  in  1  discard held/in-flight instruction; redirect to `EXC_VECTOR`.
- `branch_taken`  in  1  sampled with `rf_pc_update`; select `branch_target`.
- `branch_target`  in  32  redirect address; bits [1:0] ignored (forced 0).

## Operation
- States: `BOOT`, `REQ` (req high), `WAIT` (accepted, awaiting rvalid), `HOLD` (instruction held), `DRAIN` (awaiting a response to discard).
- Reset values: `icache_req`=0, `icache_addr`=`RESET_VECTOR`, `rf_valid`=0, `rf_load`=0, `rf_instr`=0, `rf_pc`=`RESET_VECTOR`, internal `pend`=0, `redir`=0; state `BOOT`.
- `BOOT` -> `REQ` unconditionally on the first clock after `rst` falls.
- `REQ`: `icache_req`=1, `icache_addr` stable. On accept -> `WAIT`, or -> `DRAIN` if `redir`=1.
- `WAIT`: on `icache_rvalid`, register `icache_rdata` into `rf_instr` and `icache_addr` into `rf_pc`; -> `HOLD`. If `rf_stall`=0 pulse `rf_valid` next cycle, else set `pend`.
- `HOLD`: a pulse is produced on the first cycle with `rf_stall`=0 while `pend`=1 (this clears `pend`), and on the cycle after `rf_recover`=1. `rf_recover` while `rf_stall`=1 sets `pend`. At most one pulse per cycle.
- `rf_pc_update` in `HOLD`: next addr = `branch_taken` ? {`branch_target`[31:2],2'b00} : `rf_pc`+4, mod 2^32 (wraps to 0). Clear `pend`; -> `REQ`.
- `rf_clear` (priority over `rf_pc_update`, then `rf_recover`):
  - In `HOLD`/`BOOT`: addr = `EXC_VECTOR`, -> `REQ`, `pend`=0.
  - In `WAIT`: -> `DRAIN`, load addr = `EXC_VECTOR`.
  - In `REQ` (not yet accepted): address stays stable, set `redir`, load `EXC_VECTOR` into a pending-addr register.
- `DRAIN`: on `icache_rvalid`, drop the data with no `rf_valid`; drive `EXC_VECTOR`; -> `REQ`, `redir`=0.
- `rf_pc_update`/`rf_recover` outside `HOLD`: ignored.
- `rf_clear` in `DRAIN` or in `REQ` with `redir`=1: no additional effect.
- `rst` mid-request: abandon everything immediately; in-flight responses after reset are the cache's responsibility.

## Timing
- `rf_pc_update` at cycle t -> `icache_req`=1 with new addr at t+1.
- `icache_rvalid` at cycle t (no stall) -> `rf_valid`, `rf_instr`, `rf_pc` at t+1.
- Best-case loop: request accepted at t+1, rvalid at t+2, `rf_valid` at t+3. So 3 cycles from update to the next presentation.
- `rf_recover` at t -> `rf_valid` at t+1 (if `rf_stall`=0 at t).
- `rf_stall` falling at t with `pend` -> `rf_valid` at t+1.
- `rf_clear` in `HOLD` at t -> `icache_req` with `EXC_VECTOR` at t+1.
- All outputs are registered; no combinational input-to-output path except `rf_load`, which is derived from registered outputs only.

## Test plan
- Reset release, `icache_ready`=1, rvalid 1 cycle after accept with data 32'h2408_0001 -> first req addr BFC0_0000 one cycle after reset; `rf_valid` pulse with `rf_pc`=BFC0_0000, `rf_load`=0; `rf_pc_update` -> next addr BFC0_0004.
- Word 32'h8C82_0000 (lw) -> `rf_load`=1 only during the `rf_valid` cycle. Then `rf_pc_update` with `branch_taken`=1, `branch_target`=32'h8001_0003 -> next addr 8001_0000.
- `rf_stall` high 4 cycles during rvalid -> no `rf_valid` while stalled; a single pulse the cycle after `rf_stall` falls. `rf_recover` later -> exactly one more pulse, same `rf_pc`.
- `rf_clear` while in `WAIT` (rvalid delayed 5 cycles) -> returned word dropped with no `rf_valid`; next req addr 8000_0080.
- `rf_clear` while `icache_req`=1 and `icache_ready`=0 for 3 cycles -> addr unchanged until accept; response dropped; then req 8000_0080.
- `rf_pc`=FFFF_FFFC, `rf_pc_update` with no branch -> next req addr 0000_0000.
